// File: rtl/dmem_arbiter_if.sv
// Two-master word port plus byte-wide shared memory port for dmem_arbiter.
// slave = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [31:0]       m0_addr;
    logic [31:0]       m0_wdata;
    logic [31:0]       m0_rdata;
    logic              m0_ack;

    logic              m1_req;
    logic              m1_we;
    logic [31:0]       m1_addr;
    logic [31:0]       m1_wdata;
    logic [31:0]       m1_rdata;
    logic              m1_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter serialising 32-bit word accesses into four big-endian byte beats.
// Define DMEM_ARB_RR_EN for round-robin on contested grants; default is fixed m0 priority.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t            state, state_nx;
    logic [1:0]        beat;
    logic [1:0]        lane;
    logic              gnt, gnt_nx;
    logic              we_r;
    logic [ADDR_W-3:0] base;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata0, rdata1;
    logic [ADDR_W-1:0] addr_hold;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        wbyte;
    logic              any_req;
    logic              unused_addr_bits;
`ifdef DMEM_ARB_RR_EN
    logic              prio;
`endif

    assign unused_addr_bits = ^{bus.m0_addr, bus.m1_addr};
    assign any_req  = bus.m0_req | bus.m1_req;
    assign lane     = 2'd3 - beat;
    assign cur_addr = {base, beat};
    assign wbyte    = wdata_r[{lane, 3'b000} +: 8];

    always_comb begin
        gnt_nx = !bus.m0_req;
`ifdef DMEM_ARB_RR_EN
        // Pointer only matters when both ask; a lone requester always wins.
        if (bus.m0_req && bus.m1_req) gnt_nx = prio;
`endif
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = BUSY;
            BUSY:    if (beat == 2'd3) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr  = addr_hold;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.m0_ack    = 1'b0;
        bus.m1_ack    = 1'b0;
        if (state == BUSY) begin
            bus.mem_addr  = cur_addr;
            bus.mem_we    = we_r;
            bus.mem_wdata = we_r ? wbyte : 8'h00;
        end
        if (state == ACK) begin
            bus.m0_ack = !gnt;
            bus.m1_ack = gnt;
        end
    end

    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            gnt       <= 1'b0;
            we_r      <= 1'b0;
            base      <= '0;
            wdata_r   <= '0;
            addr_hold <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
`ifdef DMEM_ARB_RR_EN
            prio      <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= gnt_nx;
                        beat    <= '0;
                        we_r    <= gnt_nx ? bus.m1_we : bus.m0_we;
                        base    <= gnt_nx ? bus.m1_addr[ADDR_W-1:2] : bus.m0_addr[ADDR_W-1:2];
                        wdata_r <= gnt_nx ? bus.m1_wdata : bus.m0_wdata;
`ifdef DMEM_ARB_RR_EN
                        if (bus.m0_req && bus.m1_req) prio <= !gnt_nx;
`endif
                    end
                end
                BUSY: begin
                    beat      <= beat + 2'd1;
                    addr_hold <= cur_addr;
                    if (!we_r) begin
                        if (gnt) rdata1[{lane, 3'b000} +: 8] <= bus.mem_rdata;
                        else     rdata0[{lane, 3'b000} +: 8] <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
